seg_pipe_adder: RTL and testbench



---
 rtl/seg_pipe_adder.sv | 134 +++++++++++++
 tb/tb_seg_pipe_adder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: pipelined carry-segmented adder/subtractor. One SEG_W-bit
// segment is resolved per stage, and the segment carry is registered between stages.
module seg_pipe_adder #(
  parameter int WIDTH = 24,
  parameter int SEG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG_W;

  if (SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
    $fatal(1, "seg_pipe_adder: WIDTH must be a positive multiple of SEG_W");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Subtraction is a + ~b + ~cin, so the pipeline itself only ever adds.
  assign w_b_eff   = b ^ {WIDTH{sub}};
  assign w_cin_eff = cin ^ sub;

  // Global stall: the whole pipe freezes only when a result is waiting and is not taken.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W = WIDTH - k * SEG_W;
    localparam int LO   = k * SEG_W;

    logic              w_v_in;
    logic [IN_W-1:0]   w_a_in;
    logic [IN_W-1:0]   w_b_in;
    logic              w_c_in;
    logic [WIDTH-1:0]  w_s_in;
    logic [WIDTH-1:0]  w_s_next;
    logic [SEG_W:0]    w_seg;

    logic              r_v;
    logic              r_c;
    logic [WIDTH-1:0]  r_s;

    if (k == 0) begin : g_head
      assign w_v_in = in_valid;
      assign w_a_in = a;
      assign w_b_in = w_b_eff;
      assign w_c_in = w_cin_eff;
      assign w_s_in = '0;
    end else begin : g_body
      assign w_v_in = g_stage[k-1].r_v;
      assign w_a_in = g_stage[k-1].g_skew.r_a;
      assign w_b_in = g_stage[k-1].g_skew.r_b;
      assign w_c_in = g_stage[k-1].r_c;
      assign w_s_in = g_stage[k-1].r_s;
    end

    // The low SEG_W bits of the forwarded operands always hold this stage's segment.
    assign w_seg = {1'b0, w_a_in[SEG_W-1:0]} + {1'b0, w_b_in[SEG_W-1:0]}
                 + {{SEG_W{1'b0}}, w_c_in};

    // NOTE: default first, then override, so every path assigns w_s_next and no latch appears.
    always_comb begin
      w_s_next                = w_s_in;
      w_s_next[LO +: SEG_W]   = w_seg[SEG_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all stages sample old values together.
    // NOTE: every data register is reset, because the outputs must read zero during reset.
    // Data registers load only for valid slots, so bubbles leave the held result intact.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_en) begin
        r_v <= w_v_in;
        if (w_v_in) begin
          r_c <= w_seg[SEG_W];
          r_s <= w_s_next;
        end
      end
    end

    if (IN_W > SEG_W) begin : g_skew
      logic [IN_W-SEG_W-1:0] r_a;
      logic [IN_W-SEG_W-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en && w_v_in) begin
          r_a <= w_a_in[IN_W-1:SEG_W];
          r_b <= w_b_in[IN_W-1:SEG_W];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic w_c_msb;
      logic r_ovf;

      // Recover the carry into the MSB from that bit's own sum: c = a ^ b ^ s.
      assign w_c_msb = w_a_in[SEG_W-1] ^ w_b_in[SEG_W-1] ^ w_seg[SEG_W-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_en && w_v_in) begin
          r_ovf <= w_c_msb ^ w_seg[SEG_W];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign sum       = g_stage[STAGES-1].r_s;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Scoreboard bench for seg_pipe_adder: three configurations (24/6, 12/12, 12/1)
// checked against a plain-arithmetic model of add/sub with signed overflow.
module tb_seg_pipe_adder;

  localparam int W_OF[3]   = '{24, 12, 12};
  localparam int LAT_OF[3] = '{4, 1, 12};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  cin_i;
  logic [2:0]  sub_i;
  logic [23:0] a_i [3];
  logic [23:0] b_i [3];

  wire  [2:0]  in_ready;
  wire  [2:0]  out_valid;
  wire  [2:0]  cout_o;
  wire  [2:0]  ovf_o;
  wire  [23:0] sum0;
  wire  [11:0] sum1;
  wire  [11:0] sum2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [25:0] q0[$];
  logic [25:0] q1[$];
  logic [25:0] q2[$];

  always #5 clk = ~clk;

  seg_pipe_adder #(.WIDTH(24), .SEG_W(6)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_i[0]), .b(b_i[0]), .cin(cin_i[0]), .sub(sub_i[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum0), .cout(cout_o[0]), .ovf(ovf_o[0])
  );

  seg_pipe_adder #(.WIDTH(12), .SEG_W(12)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_i[1][11:0]), .b(b_i[1][11:0]), .cin(cin_i[1]), .sub(sub_i[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum1), .cout(cout_o[1]), .ovf(ovf_o[1])
  );

  seg_pipe_adder #(.WIDTH(12), .SEG_W(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_i[2][11:0]), .b(b_i[2][11:0]), .cin(cin_i[2]), .sub(sub_i[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum2), .cout(cout_o[2]), .ovf(ovf_o[2])
  );

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] get_sum(input int d);
    case (d)
      0:       return sum0;
      1:       return {12'b0, sum1};
      default: return {12'b0, sum2};
    endcase
  endfunction

  // Reference: sum/cout/ovf from integer arithmetic on unsigned and signed views.
  function automatic logic [25:0] model(input int w, input logic [23:0] av,
                                        input logic [23:0] bv, input logic c,
                                        input logic s);
    longint full = longint'(1) << w;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(av) & (full - 1);
    longint ub   = longint'(bv) & (full - 1);
    longint sa   = (ua >= half) ? ua - full : ua;
    longint sb   = (ub >= half) ? ub - full : ub;
    longint r;
    longint sr;
    logic   co;
    logic   ov;
    logic [23:0] sm;
    if (!s) begin
      r  = ua + ub + longint'(c);
      co = (r >= full);
      sr = sa + sb + longint'(c);
    end else begin
      r  = ua - ub - longint'(c);
      co = (r >= 0);
      sr = sa - sb - longint'(c);
    end
    ov = (sr >= half) || (sr < -half);
    sm = 24'(r & (full - 1));
    return {ov, co, sm};
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int d, input logic [25:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic logic [25:0] q_pop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic q_clear();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Monitor: reset state, handshake relation, and in-order results.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        check("rst_out_valid", d, 64'(out_valid[d]), 64'd0);
        check("rst_outputs", d, 64'({ovf_o[d], cout_o[d], get_sum(d)}), 64'd0);
      end else begin
        check("in_ready_rule", d, 64'(in_ready[d]), 64'(!out_valid[d] || out_ready[d]));
        if (out_valid[d] && out_ready[d]) begin
          if (q_size(d) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out dut%0d: got %0h, expected no result (t=%0t)",
                     d, {ovf_o[d], cout_o[d], get_sum(d)}, $time);
          end else begin
            check("result", d, 64'({ovf_o[d], cout_o[d], get_sum(d)}), 64'(q_pop(d)));
          end
        end
      end
    end
  end

  // Presents one operation (called at posedge+1) and holds it until accepted.
  task automatic send(input int d, input logic [23:0] av, input logic [23:0] bv,
                      input logic c, input logic s);
    int t = 0;
    a_i[d]      = av;
    b_i[d]      = bv;
    cin_i[d]    = c;
    sub_i[d]    = s;
    in_valid[d] = 1'b1;
    @(negedge clk);
    while (!in_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[d]) begin
      check("accept_timeout", d, 64'd0, 64'd1);
    end else begin
      q_push(d, model(W_OF[d], av, bv, c, s));
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic run_single(input int d, input logic [23:0] av, input logic [23:0] bv,
                            input logic c, input logic s);
    int n;
    send(d, av, bv, c, s);
    n = 1;
    @(negedge clk);
    while (!out_valid[d] && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", d, 64'(n), 64'(LAT_OF[d]));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input int d);
    logic [23:0] mask;
    logic [23:0] av;
    logic [23:0] bv;
    logic        c;
    logic        s;
    mask = 24'((longint'(1) << W_OF[d]) - 1);
    for (int i = 0; i < 6; i++) begin
      c = 1'b0;
      s = 1'b0;
      case (i)
        0: begin av = mask;      bv = 24'd1; end
        1: begin av = mask >> 1; bv = 24'd1; end
        2: begin av = (mask >> 1) + 24'd1; bv = (mask >> 1) + 24'd1; end
        3: begin av = 24'd5; bv = 24'd7; s = 1'b1; end
        4: begin av = 24'd5; bv = 24'd7; s = 1'b1; c = 1'b1; end
        default: begin av = 24'd7; bv = 24'd5; s = 1'b1; end
      endcase
      run_single(d, av, bv, c, s);
    end
  endtask

  task automatic stream(input int d);
    int t = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(d, 24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready[d] = 1'b1;
      end
    join
    while (q_size(d) != 0 && t < 64) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", d, 64'(q_size(d)), 64'd0);
  endtask

  task automatic mid_reset(input int d);
    logic seen;
    for (int i = 0; i < 3; i++) begin
      send(d, 24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", d, 64'(out_valid[d]), 64'd0);
    check("midrst_outputs", d, 64'({ovf_o[d], cout_o[d], get_sum(d)}), 64'd0);
    q_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (2 * LAT_OF[d] + 4) begin
      @(negedge clk);
      if (out_valid[d]) seen = 1'b1;
    end
    check("stale_out", d, 64'(seen), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = '1;
    cin_i     = '1;
    sub_i     = '0;
    for (int d = 0; d < 3; d++) begin
      a_i[d] = 24'($urandom);
      b_i[d] = 24'($urandom);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("post_reset_in_ready", d, 64'(in_ready[d]), 64'd1);
    end

    for (int d = 0; d < 3; d++) begin
      directed(d);
      stream(d);
      if (LAT_OF[d] > 1) mid_reset(d);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
